// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle main controller and its datapath.
// master = controller side, slave = datapath/memory side.
interface multicycle_ctrl_if;
    logic [6:0] op;
    logic       zero;
    logic       mem_ready;

    logic       pc_update;
    logic       branch;
    logic       ir_write;
    logic       reg_write;
    logic       mem_write;
    logic       mem_req;
    logic       adr_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;
    logic [1:0] imm_src;
    logic       instr_done;
    logic       trap;

    modport master (
        input  op, zero, mem_ready,
        output pc_update, branch, ir_write, reg_write, mem_write, mem_req,
               adr_src, alu_src_a, alu_src_b, alu_op, result_src, imm_src,
               instr_done, trap
    );

    modport slave (
        output op, zero, mem_ready,
        input  pc_update, branch, ir_write, reg_write, mem_write, mem_req,
               adr_src, alu_src_a, alu_src_b, alu_op, result_src, imm_src,
               instr_done, trap
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Moore main controller for a multicycle RV32I subset (lw, sw, R, I-ALU, beq, jal).
// Latency with memory ready: lw 5, sw 4, R/I 4, beq 3, jal 4 cycles.
// Backpressure: FETCH, MEMREAD and MEMWR hold while mem_ready is low (MEM_HANDSHAKE=1).
module multicycle_ctrl #(
    parameter bit MEM_HANDSHAKE = 1'b1
) (
    input  logic                clk,
    input  logic                reset_n,
    multicycle_ctrl_if.master   bus
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMREAD = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECR   = 4'd6,
        EXECI   = 4'd7,
        ALUWB   = 4'd8,
        BEQ     = 4'd9,
        JAL     = 4'd10,
        TRAP    = 4'd11
    } state_t;

    typedef struct packed {
        logic       pc_update;
        logic       branch;
        logic       ir_write;
        logic       reg_write;
        logic       mem_write;
        logic       mem_req;
        logic       adr_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] result_src;
        logic       instr_done;
        logic       trap;
    } ctl_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    state_t state;
    state_t state_nxt;
    ctl_t   ctl_q;
    logic   rdy;
    logic   legal;
    logic   en;
    logic   unused_ok;

    assign rdy       = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;
    assign unused_ok = bus.zero;

    // Unconditional decode per state; rdy-qualified enables are masked afterwards.
    function automatic ctl_t decode(input state_t s);
        ctl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.mem_req    = 1'b1;
                c.alu_src_b  = 2'b10;
                c.result_src = 2'b10;
                c.ir_write   = 1'b1;
                c.pc_update  = 1'b1;
            end
            DECODE: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b01;
            end
            MEMADR: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
            end
            MEMREAD: begin
                c.mem_req = 1'b1;
                c.adr_src = 1'b1;
            end
            MEMWB: begin
                c.result_src = 2'b01;
                c.reg_write  = 1'b1;
                c.instr_done = 1'b1;
            end
            MEMWR: begin
                c.mem_req    = 1'b1;
                c.adr_src    = 1'b1;
                c.mem_write  = 1'b1;
                c.instr_done = 1'b1;
            end
            EXECR: begin
                c.alu_src_a = 2'b10;
                c.alu_op    = 2'b10;
            end
            EXECI: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
                c.alu_op    = 2'b10;
            end
            ALUWB: begin
                c.reg_write  = 1'b1;
                c.instr_done = 1'b1;
            end
            BEQ: begin
                c.alu_src_a  = 2'b10;
                c.alu_op     = 2'b01;
                c.branch     = 1'b1;
                c.instr_done = 1'b1;
            end
            JAL: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b10;
                c.pc_update = 1'b1;
            end
            TRAP: begin
                c.trap = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        state_nxt = FETCH;
        case (state)
            FETCH:   state_nxt = rdy ? DECODE : FETCH;
            DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: state_nxt = MEMADR;
                    OP_R:         state_nxt = EXECR;
                    OP_I:         state_nxt = EXECI;
                    OP_BEQ:       state_nxt = BEQ;
                    OP_JAL:       state_nxt = JAL;
                    default:      state_nxt = TRAP;
                endcase
            end
            MEMADR:  state_nxt = (bus.op == OP_LW) ? MEMREAD : MEMWR;
            MEMREAD: state_nxt = rdy ? MEMWB : MEMREAD;
            MEMWB:   state_nxt = FETCH;
            MEMWR:   state_nxt = rdy ? FETCH : MEMWR;
            EXECR:   state_nxt = ALUWB;
            EXECI:   state_nxt = ALUWB;
            ALUWB:   state_nxt = FETCH;
            BEQ:     state_nxt = FETCH;
            JAL:     state_nxt = ALUWB;
            TRAP:    state_nxt = TRAP;
            default: state_nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= FETCH;
            ctl_q <= decode(FETCH);
        end else begin
            state <= state_nxt;
            ctl_q <= decode(state_nxt);
        end
    end

    // A corrupted state register must not leak stale registered controls.
    assign legal = (state <= TRAP);
    assign en    = reset_n & legal;

    always_comb begin
        bus.pc_update  = ctl_q.pc_update & en & ((state == FETCH) ? rdy : 1'b1);
        bus.ir_write   = ctl_q.ir_write  & en & rdy;
        bus.branch     = ctl_q.branch    & en;
        bus.reg_write  = ctl_q.reg_write & en;
        bus.mem_write  = ctl_q.mem_write & en;
        bus.mem_req    = ctl_q.mem_req   & en;
        bus.instr_done = ctl_q.instr_done & en & ((state == MEMWR) ? rdy : 1'b1);
        bus.adr_src    = ctl_q.adr_src & legal;
        bus.alu_src_a  = ctl_q.alu_src_a  & {2{legal}};
        bus.alu_src_b  = ctl_q.alu_src_b  & {2{legal}};
        bus.alu_op     = ctl_q.alu_op     & {2{legal}};
        bus.result_src = ctl_q.result_src & {2{legal}};
        bus.trap       = ctl_q.trap & legal;
    end

    always_comb begin
        case (bus.op)
            OP_LW, OP_I: bus.imm_src = 2'b00;
            OP_SW:       bus.imm_src = 2'b01;
            OP_BEQ:      bus.imm_src = 2'b10;
            OP_JAL:      bus.imm_src = 2'b11;
            default:     bus.imm_src = 2'b00;
        endcase
    end

endmodule
